// File: rtl/ztex_host_port.sv
// Host-side byte port for ZTEX miner tops: assembles work records from the read bus,
// queues golden nonces from N hashcores and serialises status records on the write bus.
module ztex_host_port #(
  parameter int IN_BYTES   = 80,
  parameter int N_CORES    = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rd_clk,
  input  logic                    wr_clk,
  input  logic                    wr_start,
  input  logic [7:0]              read,
  output logic [7:0]              write,
  output logic [8*IN_BYTES-1:0]   work_data,
  output logic                    work_load,
  input  logic [31:0]             cur_nonce,
  input  logic [32*N_CORES-1:0]   nonce_in,
  input  logic [N_CORES-1:0]      nonce_valid,
  output logic [N_CORES-1:0]      nonce_ack
);

  localparam int WW = 8 * IN_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int BW = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;

  logic [3:0]      rd_s;
  logic [3:0]      wr_s;
  logic [2:0]      ws_s;
  logic [7:0]      read_r;
  logic            rd_ev;
  logic            wr_ev;
  logic            ws;
  logic            snap;

  logic [WW-1:0]   shreg;
  logic [BW-1:0]   byte_cnt;
  logic [15:0]     work_count;

  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;
  logic [AW:0]     level;
  logic [AW:0]     level_after;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [31:0]     head;
  logic [31:0]     status;

  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   grant;
  logic [CW-1:0]   grant_next;
  logic [CW-1:0]   idx;
  logic            grant_vld;
  logic [N_CORES-1:0] elig;
  logic [31:0]     nonce_sel;

  logic [95:0]     outbuf;
  logic [4:0]      wr_delay;

  // s[3] is the newest sample; an event needs the new level stable for three cycles
  assign rd_ev = (rd_s[3] == rd_s[2]) && (rd_s[2] == rd_s[1]) && (rd_s[1] != rd_s[0]);
  assign wr_ev = (wr_s[3] == wr_s[2]) && (wr_s[2] == wr_s[1]) && (wr_s[1] != wr_s[0]);
  assign ws    = ws_s[1];
  assign snap  = ws_s[1] & ~ws_s[2];

  assign level       = wptr - rptr;
  assign full        = (level == (AW+1)'(FIFO_DEPTH));
  assign empty       = (level == '0);
  assign pop         = snap && !empty;
  assign push        = grant_vld && !full;
  assign level_after = level - (AW+1)'(pop);
  assign head        = mem[rptr[AW-1:0]];
  assign status      = {work_count, 7'd0, ~empty, 8'(level_after)};

  // A core whose ack is in flight has not yet dropped valid, so it is masked
  assign elig       = nonce_valid & ~nonce_ack;
  assign nonce_sel  = nonce_in[32*grant +: 32];
  assign grant_next = (int'(grant) == N_CORES - 1) ? '0 : grant + CW'(1);

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    for (int j = 0; j < N_CORES; j++) begin
      idx = CW'((int'(rr_ptr) + j) % N_CORES);
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_s       <= '0;
      wr_s       <= '0;
      ws_s       <= '0;
      read_r     <= '0;
      byte_cnt   <= '0;
      work_data  <= '0;
      work_load  <= 1'b0;
      work_count <= '0;
      wptr       <= '0;
      rptr       <= '0;
      rr_ptr     <= '0;
      nonce_ack  <= '0;
      wr_delay   <= '0;
      outbuf     <= '0;
      write      <= '0;
    end else begin
      rd_s   <= {rd_clk, rd_s[3:1]};
      wr_s   <= {wr_clk, wr_s[3:1]};
      ws_s   <= {ws_s[1:0], wr_start};
      read_r <= read;

      // A snapshot resynchronises framing: any partial record is dropped
      work_load <= 1'b0;
      if (snap) begin
        byte_cnt <= '0;
      end else if (rd_ev) begin
        if (byte_cnt == BW'(IN_BYTES - 1)) begin
          byte_cnt  <= '0;
          work_data <= {read_r, shreg[WW-1:8]};
          work_load <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + BW'(1);
        end
      end
      if (work_load) work_count <= work_count + 16'd1;

      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
      nonce_ack <= '0;
      if (push) begin
        nonce_ack[grant] <= 1'b1;
        rr_ptr           <= grant_next;
      end

      // Readout strobes are honoured only once wr_start has been low for a while
      wr_delay <= ws ? 5'd0 : {wr_delay[3:0], 1'b1};
      if (snap)
        outbuf <= {status, cur_nonce, empty ? 32'd0 : head};
      else if (wr_ev && wr_delay[4])
        outbuf <= {8'd0, outbuf[95:8]};
      write <= outbuf[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_ev) shreg <= {read_r, shreg[WW-1:8]};
    if (push)  mem[wptr[AW-1:0]] <= nonce_sel;
  end

endmodule

// File: tb/tb_ztex_host_port.sv
// Scoreboard bench for ztex_host_port: queue-based reference of frames, nonce FIFO
// and snapshot records; a negedge monitor compares everything the DUT presents.
module tb_ztex_host_port;

  localparam int IB = 80;
  localparam int NC = 4;
  localparam int FD = 4;
  localparam int WW = 8 * IB;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            rd_clk = 1'b0;
  logic            wr_clk = 1'b0;
  logic            wr_start = 1'b0;
  logic [7:0]      read = 8'd0;
  logic [7:0]      write;
  logic [WW-1:0]   work_data;
  logic            work_load;
  logic [31:0]     cur_nonce = 32'd0;
  logic [32*NC-1:0] nonce_in;
  logic [NC-1:0]   nonce_valid;
  logic [NC-1:0]   nonce_ack;

  ztex_host_port #(.IN_BYTES(IB), .N_CORES(NC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .rd_clk(rd_clk), .wr_clk(wr_clk),
    .wr_start(wr_start), .read(read), .write(write), .work_data(work_data),
    .work_load(work_load), .cur_nonce(cur_nonce), .nonce_in(nonce_in),
    .nonce_valid(nonce_valid), .nonce_ack(nonce_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [WW-1:0] act;
    logic [WW-1:0] exp;
  } chk_t;

  chk_t          chk_q[$];
  logic [WW-1:0] exp_work_q[$];
  int            exp_ack_q[$];
  logic [95:0]   exp_snap_q[$];
  int            n_tests = 0;
  int            n_fail = 0;

  // Reference state: bytes of the open frame, FIFO contents, round-robin position
  logic [7:0]    frame_q[$];
  logic [31:0]   mfifo[$];
  int            mrr = 0;
  logic [NC-1:0] mpend = '0;
  logic [15:0]   mcount = 16'd0;

  logic [31:0]   core_val [NC] = '{default: 32'd0};
  logic [7:0]    raise_cnt [NC] = '{default: 8'd0};
  logic [7:0]    ack_cnt [NC] = '{default: 8'd0};

  always_comb begin
    nonce_in    = '0;
    nonce_valid = '0;
    for (int i = 0; i < NC; i++) begin
      nonce_in[32*i +: 32] = core_val[i];
      nonce_valid[i]       = (raise_cnt[i] != ack_cnt[i]);
    end
  end

  function automatic void cmp(string n, logic [WW-1:0] a, logic [WW-1:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", n, a, e);
    end
  endfunction

  task automatic push_chk(string n, logic [WW-1:0] a, logic [WW-1:0] e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  always @(negedge clk) begin : monitor
    chk_t c;
    if (reset_n && work_load) begin
      if (exp_work_q.size() == 0) cmp("work_load_unexpected", WW'(work_load), WW'(0));
      else cmp("work_data", work_data, exp_work_q.pop_front());
    end
    if (reset_n) begin
      for (int i = 0; i < NC; i++) begin
        if (nonce_ack[i]) begin
          ack_cnt[i] <= ack_cnt[i] + 8'd1;
          if (exp_ack_q.size() == 0) cmp("ack_unexpected", WW'(i), WW'(NC));
          else cmp("ack_core", WW'(i), WW'(exp_ack_q.pop_front()));
        end
      end
    end
    while (chk_q.size() != 0) begin
      c = chk_q.pop_front();
      cmp(c.name, c.act, c.exp);
    end
  end

  function automatic void m_arbitrate();
    while (mpend != '0 && mfifo.size() < FD) begin
      for (int j = 0; j < NC; j++) begin
        int c = (mrr + j) % NC;
        if (mpend[c]) begin
          mfifo.push_back(core_val[c]);
          exp_ack_q.push_back(c);
          mpend[c] = 1'b0;
          mrr = (c + 1) % NC;
          break;
        end
      end
    end
  endfunction

  function automatic void m_snapshot();
    logic [31:0] gn;
    logic        vld;
    frame_q.delete();
    vld = (mfifo.size() != 0);
    gn  = vld ? mfifo.pop_front() : 32'd0;
    exp_snap_q.push_back({mcount, 7'd0, vld, 8'(mfifo.size()), cur_nonce, gn});
    m_arbitrate();
  endfunction

  function automatic void m_byte(logic [7:0] b);
    logic [WW-1:0] v;
    frame_q.push_back(b);
    if (frame_q.size() == IB) begin
      for (int i = 0; i < IB; i++) v[8*i +: 8] = frame_q[i];
      exp_work_q.push_back(v);
      mcount = mcount + 16'd1;
      frame_q.delete();
    end
  endfunction

  task automatic send_byte(logic [7:0] b);
    @(negedge clk);
    read = b;
    repeat (2) @(negedge clk);
    rd_clk = ~rd_clk;
    m_byte(b);
    repeat (6) @(negedge clk);
  endtask

  task automatic send_random(int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
  endtask

  task automatic report(logic [NC-1:0] mask, logic [31:0] base, bit rnd);
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      if (mask[i] && !mpend[i]) begin
        core_val[i]  = rnd ? $urandom : base + 32'(i);
        raise_cnt[i] = raise_cnt[i] + 8'd1;
        mpend[i]     = 1'b1;
      end
    end
    m_arbitrate();
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_ack_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    push_chk("ack_drain", WW'(exp_ack_q.size()), WW'(0));
    repeat (2) @(negedge clk);
    #1;
    push_chk("pending", WW'(nonce_valid), WW'(mpend));
  endtask

  // race_core >= 0 raises that core's nonce so it is captured on the snapshot edge
  task automatic snapshot(int nbytes, int race_core);
    logic [95:0] rec;
    @(negedge clk);
    wr_start = 1'b1;
    m_snapshot();
    if (race_core >= 0) begin
      repeat (2) @(negedge clk);
      core_val[race_core]  = $urandom;
      raise_cnt[race_core] = raise_cnt[race_core] + 8'd1;
      mpend[race_core]     = 1'b1;
      m_arbitrate();
      repeat (2) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    wr_start = 1'b0;
    repeat (10) @(negedge clk);
    rec = exp_snap_q.pop_front();
    for (int i = 0; i < nbytes; i++) begin
      push_chk($sformatf("snap_byte%0d", i), WW'(write), WW'(rec[8*i +: 8]));
      wr_clk = ~wr_clk;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    push_chk("rst_write", WW'(write), WW'(0));
    push_chk("rst_work_load", WW'(work_load), WW'(0));
    push_chk("rst_nonce_ack", WW'(nonce_ack), WW'(0));
    push_chk("rst_work_data", work_data, WW'(0));
    frame_q.delete();
    mfifo.delete();
    exp_snap_q.delete();
    mrr    = 0;
    mcount = 16'd0;
    rd_clk   = 1'b0;
    wr_clk   = 1'b0;
    wr_start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : watchdog
    #800us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    #1;
    push_chk("init_write", WW'(write), WW'(0));
    push_chk("init_work_load", WW'(work_load), WW'(0));
    push_chk("init_nonce_ack", WW'(nonce_ack), WW'(0));
    push_chk("init_work_data", work_data, WW'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Counting frame, then a partial frame cut by a snapshot, then a clean frame
    for (int b = 0; b < IB; b++) send_byte(8'(b));
    repeat (4) @(negedge clk);
    push_chk("frame1_first", WW'(work_data[7:0]), WW'(8'h00));
    push_chk("frame1_last", WW'(work_data[WW-1 -: 8]), WW'(8'h4F));
    send_random(IB - 1);
    snapshot(0, -1);
    send_random(IB);
    repeat (4) @(negedge clk);

    // All four cores at once, then an extra report against a full FIFO
    report(4'hF, 32'hA000_0000, 1'b0);
    wait_idle();
    report(4'h1, 32'hB000_0000, 1'b0);
    repeat (30) @(negedge clk);
    wait_idle();
    for (int k = 0; k < FD + 1; k++) begin
      cur_nonce = $urandom;
      snapshot(12, -1);
      wait_idle();
    end

    // Single report, read back, then an empty snapshot
    cur_nonce = 32'hCAFE_F00D;
    report(4'h1, 32'h1234_5678, 1'b0);
    wait_idle();
    snapshot(12, -1);
    wait_idle();
    snapshot(12, -1);
    wait_idle();

    // Push on the very edge the snapshot pops an empty FIFO
    snapshot(12, 2);
    wait_idle();
    snapshot(12, -1);
    wait_idle();

    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(0, 2))
        0: send_random(IB);
        1: begin
          send_random($urandom_range(1, IB - 1));
          cur_nonce = $urandom;
          snapshot(12, -1);
          wait_idle();
        end
        default: ;
      endcase
      report(4'($urandom_range(0, 15)) & ~mpend, 32'd0, 1'b1);
      wait_idle();
      if ($urandom_range(0, 1) == 1 || mpend != '0) begin
        cur_nonce = $urandom;
        snapshot(12, -1);
        wait_idle();
      end
    end

    for (int k = 0; k < 10 && (mfifo.size() != 0 || mpend != '0); k++) begin
      snapshot(12, -1);
      wait_idle();
    end

    // Reset in the middle of a frame and of a readout
    send_random(30);
    report(4'h2, 32'h5A5A_0000, 1'b1);
    wait_idle();
    cur_nonce = 32'h8765_4321;
    snapshot(3, -1);
    do_reset_mid();
    send_random(IB);
    repeat (4) @(negedge clk);
    cur_nonce = 32'h0BAD_BEEF;
    snapshot(12, -1);
    wait_idle();

    push_chk("work_queue_empty", WW'(exp_work_q.size()), WW'(0));
    push_chk("ack_queue_empty", WW'(exp_ack_q.size()), WW'(0));
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
